// File: rtl/cnn_layer_accel_rb_job_ctrl.sv
// cnn_layer_accel_rb_job_ctrl: accepts a convolution job and walks its output
// beats in the order (row, col, kernel), with the kernel index innermost. It
// then reports completion and waits for an acknowledge.
// Optional macro CNL_RB_CYCLE_CNT_EN builds the RUN-state cycle counter.
// When the macro is undefined, cycle_counter is tied to zero.
module cnn_layer_accel_rb_job_ctrl #(
  parameter int unsigned C_DIM_WIDTH = 10,
  parameter int unsigned C_CYC_WIDTH = 32
) (
  input  logic                   clk_core,
  input  logic                   rst,
  input  logic                   job_start,
  output logic                   job_accept,
  input  logic [127:0]           job_parameters,
  output logic                   job_complete,
  input  logic                   job_complete_ack,
  output logic                   job_error,
  output logic                   seq_valid,
  input  logic                   seq_ready,
  output logic [C_DIM_WIDTH-1:0] output_row,
  output logic [C_DIM_WIDTH-1:0] output_col,
  output logic [C_DIM_WIDTH-1:0] kernel_idx,
  output logic                   last_kernel,
  output logic                   last_pixel,
  output logic [C_CYC_WIDTH-1:0] cycle_counter
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam logic [C_DIM_WIDTH-1:0] ONE = C_DIM_WIDTH'(1);

  state_t                 state_q;
  logic                   accept_q, complete_q, error_q, valid_q;
  logic                   last_kernel_q, last_pixel_q;
  logic [C_DIM_WIDTH-1:0] row_q, col_q, k_q;
  logic [C_DIM_WIDTH-1:0] orm1_q, ocm1_q, nkm1_q;

  logic [C_DIM_WIDTH-1:0] p_rows, p_cols, p_nk, p_ks;
  logic [C_DIM_WIDTH-1:0] p_orm1, p_ocm1, p_nkm1;
  logic                   p_err, p_first_last_k, p_first_last_px;
  logic [C_DIM_WIDTH-1:0] row_d, col_d, k_d;
  logic                   k_wrap, c_wrap, last_kernel_d, last_pixel_d;
  logic                   unused_params;

  // Decode the parameter word and validate it (only used on the accept cycle).
  assign p_rows          = C_DIM_WIDTH'(job_parameters[9:0]);
  assign p_cols          = C_DIM_WIDTH'(job_parameters[19:10]);
  assign p_nk            = C_DIM_WIDTH'(job_parameters[29:20]);
  assign p_ks            = C_DIM_WIDTH'(job_parameters[33:30]);
  assign p_err           = (p_ks == '0) || (p_nk == '0) || (p_ks > p_rows) || (p_ks > p_cols);
  assign p_orm1          = p_rows - p_ks;
  assign p_ocm1          = p_cols - p_ks;
  assign p_nkm1          = p_nk - ONE;
  assign p_first_last_k  = (p_nkm1 == '0);
  assign p_first_last_px = p_first_last_k && (p_orm1 == '0) && (p_ocm1 == '0);
  assign unused_params   = ^job_parameters[127:34];

  // Next beat indices after a handshake; the kernel index is innermost.
  always_comb begin
    k_wrap        = (k_q == nkm1_q);
    c_wrap        = (col_q == ocm1_q);
    k_d           = k_q + ONE;
    col_d         = col_q;
    row_d         = row_q;
    if (k_wrap) begin
      k_d   = '0;
      col_d = col_q + ONE;
      if (c_wrap) begin
        col_d = '0;
        row_d = row_q + ONE;
      end
    end
    last_kernel_d = (k_d == nkm1_q);
    last_pixel_d  = last_kernel_d && (col_d == ocm1_q) && (row_d == orm1_q);
  end

  // Job FSM with registered handshake and beat outputs.
  always_ff @(posedge clk_core) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      accept_q      <= 1'b0;
      complete_q    <= 1'b0;
      error_q       <= 1'b0;
      valid_q       <= 1'b0;
      last_kernel_q <= 1'b0;
      last_pixel_q  <= 1'b0;
      row_q         <= '0;
      col_q         <= '0;
      k_q           <= '0;
      orm1_q        <= '0;
      ocm1_q        <= '0;
      nkm1_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_q) begin
            // Accept cycle: parameters are sampled and checked now.
            accept_q      <= 1'b0;
            orm1_q        <= p_orm1;
            ocm1_q        <= p_ocm1;
            nkm1_q        <= p_nkm1;
            row_q         <= '0;
            col_q         <= '0;
            k_q           <= '0;
            if (p_err) begin
              state_q    <= ST_DONE;
              complete_q <= 1'b1;
              error_q    <= 1'b1;
            end else begin
              state_q       <= ST_RUN;
              valid_q       <= 1'b1;
              error_q       <= 1'b0;
              last_kernel_q <= p_first_last_k;
              last_pixel_q  <= p_first_last_px;
            end
          end else if (job_start) begin
            accept_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (seq_ready) begin
            if (last_pixel_q) begin
              state_q       <= ST_DONE;
              valid_q       <= 1'b0;
              complete_q    <= 1'b1;
              last_kernel_q <= 1'b0;
              last_pixel_q  <= 1'b0;
              row_q         <= '0;
              col_q         <= '0;
              k_q           <= '0;
            end else begin
              row_q         <= row_d;
              col_q         <= col_d;
              k_q           <= k_d;
              last_kernel_q <= last_kernel_d;
              last_pixel_q  <= last_pixel_d;
            end
          end
        end
        ST_DONE: begin
          if (job_complete_ack) begin
            state_q    <= ST_IDLE;
            complete_q <= 1'b0;
            error_q    <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef CNL_RB_CYCLE_CNT_EN
  logic [C_CYC_WIDTH-1:0] cyc_q;

  // RUN-state cycle count: cleared on accept, saturating, held elsewhere.
  always_ff @(posedge clk_core) begin
    if (rst) begin
      cyc_q <= '0;
    end else if ((state_q == ST_IDLE) && accept_q) begin
      cyc_q <= '0;
    end else if ((state_q == ST_RUN) && (cyc_q != '1)) begin
      cyc_q <= cyc_q + C_CYC_WIDTH'(1);
    end
  end

  assign cycle_counter = cyc_q;
`else
  assign cycle_counter = '0;
`endif

  assign job_accept   = accept_q;
  assign job_complete = complete_q;
  assign job_error    = error_q;
  assign seq_valid    = valid_q;
  assign output_row   = row_q;
  assign output_col   = col_q;
  assign kernel_idx   = k_q;
  assign last_kernel  = last_kernel_q;
  assign last_pixel   = last_pixel_q;

endmodule

// File: tb/tb_cnn_layer_accel_rb_job_ctrl.sv
// Self-checking bench for cnn_layer_accel_rb_job_ctrl: a table of directed jobs
// plus a hand-written reset-during-run sequence.
module tb_cnn_layer_accel_rb_job_ctrl;

  localparam int unsigned DW = 10;
  localparam int unsigned CW = 32;

`ifdef CNL_RB_CYCLE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic          clk_core = 1'b0;
  logic          rst;
  logic          job_start;
  logic          job_accept;
  logic [127:0]  job_parameters;
  logic          job_complete;
  logic          job_complete_ack;
  logic          job_error;
  logic          seq_valid;
  logic          seq_ready;
  logic [DW-1:0] output_row;
  logic [DW-1:0] output_col;
  logic [DW-1:0] kernel_idx;
  logic          last_kernel;
  logic          last_pixel;
  logic [CW-1:0] cycle_counter;

  int n_cmp  = 0;
  int n_fail = 0;

  cnn_layer_accel_rb_job_ctrl #(.C_DIM_WIDTH(DW), .C_CYC_WIDTH(CW)) dut (
    .clk_core(clk_core), .rst(rst), .job_start(job_start), .job_accept(job_accept),
    .job_parameters(job_parameters), .job_complete(job_complete),
    .job_complete_ack(job_complete_ack), .job_error(job_error),
    .seq_valid(seq_valid), .seq_ready(seq_ready), .output_row(output_row),
    .output_col(output_col), .kernel_idx(kernel_idx), .last_kernel(last_kernel),
    .last_pixel(last_pixel), .cycle_counter(cycle_counter)
  );

  always #5 clk_core = ~clk_core;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int rows;
    int cols;
    int nk;
    int ks;
    int ready_mode;   // 0: always ready, 1: pattern 1,0,0,1
    bit ack_noise;    // pulse job_complete_ack during RUN (must be ignored)
    int exp_beats;
    bit exp_err;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_accept"}, job_accept, 0);
    chk({tag, "_complete"}, job_complete, 0);
    chk({tag, "_error"}, job_error, 0);
    chk({tag, "_valid"}, seq_valid, 0);
    chk({tag, "_row"}, output_row, 0);
    chk({tag, "_col"}, output_col, 0);
    chk({tag, "_kidx"}, kernel_idx, 0);
    chk({tag, "_lastk"}, last_kernel, 0);
    chk({tag, "_lastpx"}, last_pixel, 0);
    chk({tag, "_cyc"}, cycle_counter, 0);
  endtask

  // Raise job_start with the given fields and wait (bounded) for the accept pulse.
  task automatic request(input vec_t v, output bit ok);
    int cyc;
    job_parameters          = '0;
    job_parameters[127:34]  = 94'({$urandom(), $urandom(), $urandom()});
    job_parameters[9:0]     = v.rows[9:0];
    job_parameters[19:10]   = v.cols[9:0];
    job_parameters[29:20]   = v.nk[9:0];
    job_parameters[33:30]   = v.ks[3:0];
    job_start = 1'b1;
    cyc = 0;
    while (job_accept !== 1'b1 && cyc < 10) begin
      tick();
      cyc++;
    end
    chk("accept_seen", job_accept, 1);
    ok = (job_accept === 1'b1);
  endtask

  task automatic finish_done(input longint exp_cyc);
    repeat (2) begin
      tick();
      chk("complete_hold", job_complete, 1);
      chk("cyc_hold_done", cycle_counter, exp_cyc);
    end
    job_complete_ack = 1'b1;
    tick();
    job_complete_ack = 1'b0;
    chk("complete_cleared", job_complete, 0);
    chk("error_cleared", job_error, 0);
    tick();
    chk("idle_no_accept", job_accept, 0);
    chk("idle_no_valid", seq_valid, 0);
  endtask

  task automatic run_job(input vec_t v);
    int orr, occ, er, ec, ek, beats, runcyc, cyc;
    bit done, ok, rdy, elast;
    request(v, ok);
    if (!ok) begin
      job_start = 1'b0;
      return;
    end
    if (!v.exp_err) job_start = 1'b0;
    tick();
    chk("accept_pulse", job_accept, 0);
    if (v.exp_err) begin
      chk("err_valid", seq_valid, 0);
      chk("err_complete", job_complete, 1);
      chk("err_flag", job_error, 1);
      chk("err_cyc", cycle_counter, 0);
      repeat (3) begin
        tick();
        chk("done_start_ignored", job_accept, 0);
        chk("done_valid", seq_valid, 0);
        chk("done_complete", job_complete, 1);
      end
      job_start = 1'b0;
      finish_done(0);
      return;
    end
    orr = v.rows - v.ks + 1;
    occ = v.cols - v.ks + 1;
    er = 0; ec = 0; ek = 0; beats = 0; runcyc = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 5000) begin
      if (seq_valid !== 1'b1) begin
        chk("valid_in_run", seq_valid, 1);
        break;
      end
      chk("cyc_run", cycle_counter, CNT_ON ? runcyc : 0);
      runcyc++;
      rdy = (v.ready_mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
      seq_ready = rdy;
      job_complete_ack = v.ack_noise && (cyc < 4);
      elast = (ek == v.nk - 1) && (ec == occ - 1) && (er == orr - 1);
      chk("beat_row", output_row, er);
      chk("beat_col", output_col, ec);
      chk("beat_kidx", kernel_idx, ek);
      chk("beat_lastk", last_kernel, (ek == v.nk - 1));
      chk("beat_lastpx", last_pixel, elast);
      chk("run_complete", job_complete, 0);
      if (rdy) begin
        beats++;
        if (elast) done = 1'b1;
        else begin
          ek++;
          if (ek == v.nk) begin
            ek = 0;
            ec++;
            if (ec == occ) begin
              ec = 0;
              er++;
            end
          end
        end
      end
      tick();
      cyc++;
    end
    seq_ready = 1'b0;
    job_complete_ack = 1'b0;
    chk("beat_count", beats, v.exp_beats);
    chk("post_valid", seq_valid, 0);
    chk("post_complete", job_complete, 1);
    chk("post_error", job_error, 0);
    chk("post_cyc", cycle_counter, CNT_ON ? runcyc : 0);
    finish_done(CNT_ON ? runcyc : 0);
  endtask

  vec_t vecs[7];

  initial begin
    bit ok;
    vec_t rv;
    vecs[0] = '{rows: 5,  cols: 5,  nk: 2, ks: 3, ready_mode: 0, ack_noise: 1, exp_beats: 18,  exp_err: 0};
    vecs[1] = '{rows: 19, cols: 19, nk: 1, ks: 3, ready_mode: 0, ack_noise: 0, exp_beats: 289, exp_err: 0};
    vecs[2] = '{rows: 5,  cols: 5,  nk: 2, ks: 3, ready_mode: 1, ack_noise: 0, exp_beats: 18,  exp_err: 0};
    vecs[3] = '{rows: 5,  cols: 5,  nk: 2, ks: 6, ready_mode: 0, ack_noise: 0, exp_beats: 0,   exp_err: 1};
    vecs[4] = '{rows: 5,  cols: 5,  nk: 0, ks: 3, ready_mode: 0, ack_noise: 0, exp_beats: 0,   exp_err: 1};
    vecs[5] = '{rows: 4,  cols: 7,  nk: 3, ks: 4, ready_mode: 1, ack_noise: 0, exp_beats: 12,  exp_err: 0};
    vecs[6] = '{rows: 5,  cols: 5,  nk: 1, ks: 0, ready_mode: 0, ack_noise: 0, exp_beats: 0,   exp_err: 1};

    rst = 1'b1;
    job_start = 1'b0;
    job_parameters = '0;
    job_complete_ack = 1'b0;
    seq_ready = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_job(vecs[i]);

    // Reset in the middle of a job: after 7 beats of an 18-beat job.
    rv = vecs[0];
    request(rv, ok);
    job_start = 1'b0;
    if (ok) begin
      tick();
      seq_ready = 1'b1;
      repeat (7) tick();
      chk("pre_rst_valid", seq_valid, 1);
      chk("pre_rst_kidx", kernel_idx, 1);
      chk("pre_rst_col", output_col, 0);
      chk("pre_rst_row", output_row, 1);
      rst = 1'b1;
      tick();
      seq_ready = 1'b0;
      check_all_zero("midrst");
      rst = 1'b0;
      repeat (2) begin
        tick();
        chk("abandoned_no_complete", job_complete, 0);
      end
    end
    rv = '{rows: 5, cols: 5, nk: 1, ks: 3, ready_mode: 0, ack_noise: 0, exp_beats: 9, exp_err: 0};
    run_job(rv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
